rs_syndrome_calc: RTL and testbench



---
 rtl/rs_syndrome_calc.sv | 70 +++++++
 tb/tb_rs_syndrome_calc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc: RS(15,9) GF(16) syndrome calculator, Horner evaluation at alpha^1..alpha^6, one symbol per clock.
module rs_syndrome_calc #(
  parameter int SYM_W = 4,
  parameter int N_SYM = 15,
  parameter int N_SYN = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SYM_W*N_SYM-1:0]   codeWordVector,
  input  logic                     loadCodeword,
  output logic                     syndromeBusy,
  output logic                     syndromeValid,
  output logic [SYM_W*N_SYN-1:0]   syndromeVector,
  output logic                     errorDetected
);
  localparam int IW = $clog2(N_SYM);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic [SYM_W*N_SYM-1:0] cw;
  logic [SYM_W*N_SYN-1:0] acc, acc_nxt;
  logic [SYM_W-1:0] sym;
  // multiply by alpha modulo x^4+x+1: pure XOR shift network
  function automatic logic [SYM_W-1:0] mul_a(input logic [SYM_W-1:0] a);
    return {a[2], a[1], a[0] ^ a[3], a[3]};
  endfunction
  function automatic logic [SYM_W-1:0] mul_pow(input logic [SYM_W-1:0] a, input int n);
    logic [SYM_W-1:0] r;
    r = a;
    for (int k = 0; k < n; k++) r = mul_a(r);
    return r;
  endfunction
  assign sym = SYM_W'(cw >> (SYM_W * idx));
  genvar j;
  for (j = 0; j < N_SYN; j++) begin : g_syn
    assign acc_nxt[j*SYM_W +: SYM_W] = mul_pow(acc[j*SYM_W +: SYM_W], j + 1) ^ sym;
  end
  assign syndromeBusy = (state == RUN);
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (loadCodeword ? RUN : IDLE) : ((idx == '0) ? IDLE : RUN);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      cw             <= '0;
      acc            <= '0;
      syndromeValid  <= 1'b0;
      syndromeVector <= '0;
      errorDetected  <= 1'b0;
    end else begin
      state         <= state_nxt;
      syndromeValid <= 1'b0;
      if (state == IDLE && loadCodeword) begin
        cw  <= codeWordVector;
        acc <= '0;
        idx <= IW'(N_SYM - 1);
      end else if (state == RUN) begin
        acc <= acc_nxt;
        idx <= idx - 1'b1;
        if (idx == '0) begin
          syndromeVector <= acc_nxt;
          errorDetected  <= |acc_nxt;
          syndromeValid  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// tb_rs_syndrome_calc: scoreboard bench for rs_syndrome_calc using a direct-evaluation GF(16) reference.
module tb_rs_syndrome_calc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [59:0] codeWordVector = '0;
  logic loadCodeword = 1'b0;
  logic syndromeBusy, syndromeValid, errorDetected;
  logic [23:0] syndromeVector;
  int errs = 0, checks = 0, cyc = 0, busy_run = 0;
  logic prev_busy = 1'b0, abort = 1'b0;
  logic [24:0] exp_q[$];
  int load_q[$];
  logic [24:0] mon_e;
  logic [59:0] cw_a, cw_b, cw_enc;
  int t1, t2;
  rs_syndrome_calc dut (
    .clk(clk), .reset(reset), .codeWordVector(codeWordVector), .loadCodeword(loadCodeword),
    .syndromeBusy(syndromeBusy), .syndromeValid(syndromeValid),
    .syndromeVector(syndromeVector), .errorDetected(errorDetected)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    p = '0;
    for (int i = 3; i >= 0; i--) begin
      p = {p[2:0], 1'b0} ^ (p[3] ? 4'h3 : 4'h0);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction
  function automatic logic [3:0] gpow(input int e);
    logic [3:0] r;
    r = 4'h1;
    for (int i = 0; i < e % 15; i++) r = gmul(r, 4'h2);
    return r;
  endfunction
  // reference: S_j = sum_i c_i * alpha^(i*j), evaluated term by term
  function automatic logic [23:0] model(input logic [59:0] c);
    logic [23:0] s;
    logic [3:0] acc;
    s = '0;
    for (int j = 1; j <= 6; j++) begin
      acc = '0;
      for (int i = 0; i < 15; i++) acc = acc ^ gmul(c[4*i +: 4], gpow(i * j));
      s[4*(j-1) +: 4] = acc;
    end
    return s;
  endfunction
  function automatic logic [59:0] encode(input logic [35:0] msg);
    logic [3:0] g[7];
    logic [3:0] r[6];
    logic [3:0] root, fb;
    logic [59:0] c;
    for (int i = 0; i < 7; i++) g[i] = (i == 0) ? 4'h1 : 4'h0;
    for (int j = 1; j <= 6; j++) begin
      root = gpow(j);
      for (int i = 6; i >= 1; i--) g[i] = g[i-1] ^ gmul(g[i], root);
      g[0] = gmul(g[0], root);
    end
    for (int i = 0; i < 6; i++) r[i] = '0;
    for (int k = 8; k >= 0; k--) begin
      fb = msg[4*k +: 4] ^ r[5];
      for (int i = 5; i >= 1; i--) r[i] = r[i-1] ^ gmul(fb, g[i]);
      r[0] = gmul(fb, g[0]);
    end
    c = {msg, 24'h0};
    for (int i = 0; i < 6; i++) c[4*i +: 4] = r[i];
    return c;
  endfunction
  function automatic logic [59:0] rnd60();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[59:0];
  endfunction
  task automatic load(input logic [59:0] cw, input logic [23:0] e);
    codeWordVector = cw;
    loadCodeword = 1'b1;
    exp_q.push_back({|e, e});
    @(posedge clk);
    #1;
    load_q.push_back(cyc);
    loadCodeword = 1'b0;
    codeWordVector = rnd60();
  endtask
  task automatic wait_valid();
    int n;
    n = 0;
    while (!syndromeValid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!syndromeValid) chk("valid_timeout", 0, 1);
  endtask
  always @(negedge clk) begin
    if (syndromeValid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("syndromes", syndromeVector, mon_e[23:0]);
        chk("err_flag", errorDetected, mon_e[24]);
        if (load_q.size() != 0) chk("latency", cyc - load_q.pop_front(), 15);
      end
    end
    if (syndromeBusy) busy_run++;
    else if (prev_busy) begin
      if (abort) abort = 1'b0;
      else chk("busy_len", busy_run, 15);
      busy_run = 0;
    end
    prev_busy = syndromeBusy;
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", syndromeBusy, 0);
    chk("rst_valid", syndromeValid, 0);
    chk("rst_vec", syndromeVector, 0);
    chk("rst_err", errorDetected, 0);
    reset = 1'b0;
    @(negedge clk); load(60'h0, 24'h000000); wait_valid();
    @(negedge clk); load(60'h1, 24'h111111); wait_valid();
    @(negedge clk); load(60'h10, 24'hC63842); wait_valid();
    @(negedge clk); load(60'h1 << 56, 24'hA7EFD9); wait_valid();
    cw_enc = encode(36'h87);
    @(negedge clk); load(cw_enc, 24'h000000); wait_valid();
    @(negedge clk); load(cw_enc ^ 60'h10, 24'hC63842); wait_valid();
    // loads during RUN must be ignored
    cw_a = rnd60();
    cw_b = rnd60();
    @(negedge clk); load(cw_a, model(cw_a));
    repeat (3) @(negedge clk);
    codeWordVector = cw_b; loadCodeword = 1'b1;
    @(negedge clk); loadCodeword = 1'b0;
    repeat (10) @(negedge clk);
    codeWordVector = cw_b; loadCodeword = 1'b1;
    @(negedge clk); loadCodeword = 1'b0;
    wait_valid();
    repeat (20) @(negedge clk);
    // back-to-back: second load in the valid cycle
    cw_a = rnd60();
    cw_b = rnd60();
    load(cw_a, model(cw_a)); wait_valid(); t1 = cyc;
    load(cw_b, model(cw_b)); wait_valid(); t2 = cyc;
    chk("b2b_gap", t2 - t1, 16);
    // reset mid-run discards the computation
    @(negedge clk);
    cw_a = rnd60() | 60'h1;
    load(cw_a, model(cw_a));
    repeat (6) @(negedge clk);
    abort = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", syndromeBusy, 0);
    chk("mid_rst_valid", syndromeValid, 0);
    chk("mid_rst_vec", syndromeVector, 0);
    chk("mid_rst_err", errorDetected, 0);
    exp_q.delete();
    load_q.delete();
    @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);
    cw_b = rnd60();
    load(cw_b, model(cw_b)); wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cw_a = rnd60();
      if (k == 0) cw_a = encode(36'h123456789) ^ (60'h5 << 28);
      load(cw_a, model(cw_a)); wait_valid();
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
